// File: rtl/s27x_pkg.sv
// Shared constants and next-state helper for the bit-sliced s27 scan block.
// State vector layout is {S5,S6,S7} with S5 in the MSB.
package s27x_pkg;

  localparam int SW = 3;
  localparam int S5 = 2;
  localparam int S6 = 1;
  localparam int S7 = 0;

  localparam logic [SW-1:0] RST_STATE_DEF = 3'b000;

  typedef struct packed {
    logic g10;
    logic g11;
    logic g13;
  } nxt_t;

  // g = {G3,G2,G1,G0}, s = {S5,S6,S7}
  function automatic nxt_t s27_next(
    input logic [3:0]    g,
    input logic [SW-1:0] s
  );
    nxt_t r;
    logic g14, g8, g12, g15, g16, g9;
    g14   = ~g[0];
    g8    = g14 & s[S6];
    g12   = ~(g[1] | s[S7]);
    g15   = g12 | g8;
    g16   = g[3] | g8;
    g9    = ~(g16 & g15);
    r.g11 = ~(s[S5] | g9);
    r.g10 = ~(g14 | r.g11);
    r.g13 = ~(g[2] | g12);
    return r;
  endfunction

endpackage

// File: rtl/s27x_scan_lane.sv
// One s27 lane: next-state logic, state flops with scan mux, optional G17 flop.
// Scan path inside the lane is si -> S5 -> S6 -> S7 -> so.
module s27_lane
  import s27x_pkg::*;
#(
  parameter int            OUT_REG   = 1,
  parameter logic [SW-1:0] RST_STATE = RST_STATE_DEF
) (
  input  logic       ck_i,
  input  logic       rst_i,
  input  logic [3:0] g_i,
  input  logic       en_i,
  input  logic       se_i,
  input  logic       si_i,
  output logic       g17_o,
  output logic       so_o
);

  logic [SW-1:0] st_q, st_d;
  nxt_t          nx;

  // Combinational s27 gate network for the current state and inputs.
  always_comb begin
    nx = s27_next(g_i, st_q);
  end

  // Scan shift has priority; functional load only when enabled.
  always_comb begin
    st_d = st_q;
    if (se_i) begin
      st_d[S5] = si_i;
      st_d[S6] = st_q[S5];
      st_d[S7] = st_q[S6];
    end else if (en_i) begin
      st_d[S5] = nx.g10;
      st_d[S6] = nx.g11;
      st_d[S7] = nx.g13;
    end
  end

  // State flops, asynchronously forced to the reset pattern.
  always_ff @(posedge ck_i or posedge rst_i) begin
    if (rst_i) st_q <= RST_STATE;
    else       st_q <= st_d;
  end

  assign so_o = st_q[S7];

  if (OUT_REG != 0) begin : g_oreg
    logic g17_q;
    // Registered output tracks functional updates only.
    always_ff @(posedge ck_i or posedge rst_i) begin
      if (rst_i)              g17_q <= 1'b1;
      else if (!se_i && en_i) g17_q <= ~nx.g11;
    end
    assign g17_o = g17_q;
  end else begin : g_ocomb
    assign g17_o = ~nx.g11;
  end

endmodule

// File: rtl/s27x_scan.sv
// LANES independent s27 lanes with one global scan chain.
// Chain runs SI -> lane0 -> lane1 -> ... -> lane(LANES-1) -> SO.
module s27x_scan
  import s27x_pkg::*;
#(
  parameter int            LANES     = 4,
  parameter int            OUT_REG   = 1,
  parameter logic [SW-1:0] RST_STATE = RST_STATE_DEF
) (
  input  logic             CK,
  input  logic             RST,
  input  logic [LANES-1:0] G0,
  input  logic [LANES-1:0] G1,
  input  logic [LANES-1:0] G2,
  input  logic [LANES-1:0] G3,
  input  logic [LANES-1:0] EN,
  input  logic             SE,
  input  logic             SI,
  output logic [LANES-1:0] G17,
  output logic             SO
);

  logic [LANES:0] chain;

  assign chain[0] = SI;
  assign SO       = chain[LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    s27_lane #(
      .OUT_REG   (OUT_REG),
      .RST_STATE (RST_STATE)
    ) u_lane (
      .ck_i  (CK),
      .rst_i (RST),
      .g_i   ({G3[i], G2[i], G1[i], G0[i]}),
      .en_i  (EN[i]),
      .se_i  (SE),
      .si_i  (chain[i]),
      .g17_o (G17[i]),
      .so_o  (chain[i+1])
    );
  end

endmodule
